clock_generator_module: RTL and testbench
=========================================

CLOCK_GENERATOR_MODULE -- requirements
Module: clock_generator_module

Interface
REQ-001 Parameter FAST_DIV, default 2: clk cycles per clkFast period; even, >= 2.
REQ-002 Parameter SLOW_DIV, default 8: clk cycles per clkSlow period; even, >= 2, integer multiple of FAST_DIV.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  count enable; low freezes all counters and outputs.
REQ-006 clkSlow  output  1  divided clock, clk/SLOW_DIV, 50% duty, registered.
REQ-007 clkFast  output  1  divided clock, clk/FAST_DIV, 50% duty, registered.
REQ-008 slowTick  output  1  one-clk-cycle strobe marking each clkSlow rising transition.
REQ-009 fastTick  output  1  one-clk-cycle strobe marking each clkFast rising transition.

Function
REQ-010 Fast counter fcnt runs 0..FAST_DIV/2-1; width is ceil(log2(FAST_DIV/2)), minimum 1 bit.
REQ-011 On an edge with en=1 and fcnt==FAST_DIV/2-1: clkFast toggles and fcnt goes to 0; otherwise, with en=1, fcnt increments.
REQ-012 Slow counter scnt runs 0..SLOW_DIV/2-1; it toggles clkSlow and wraps by the same rule as REQ-011, using SLOW_DIV.
REQ-013 With en=0: fcnt, scnt, clkFast and clkSlow hold their values, and both ticks are 0.
REQ-014 fastTick is registered and is 1 exactly in the cycle where clkFast first reads 1 after a 0->1 toggle; otherwise 0.
REQ-015 slowTick follows the same rule as REQ-014, applied to clkSlow.
REQ-016 Every clkSlow toggle coincides with a clkFast toggle on the same clk edge; this follows from REQ-002 and the common reset.
REQ-017 When FAST_DIV=2, clkFast toggles on every enabled edge.
REQ-018 Counters never exceed their terminal value; wrap-around is always to 0.
REQ-019 en toggling mid-period resumes counting from the frozen count; there is no phase loss or glitch.
REQ-020 Outputs come directly from flops; there is no combinational path from any input to any output.
REQ-021 An illegal parameter combination (odd, < 2, or not a multiple) is rejected at elaboration.

Reset
REQ-022 When rst=1 at a clk edge: fcnt=0, scnt=0, clkFast=0, clkSlow=0, fastTick=0, slowTick=0.
REQ-023 rst has priority over en.
REQ-024 Reset asserted mid-period aborts the current period; the first edge after deassertion counts as count 0.

Configuration
REQ-025 Macro CLKGEN_TICK_EN: when defined, fastTick and slowTick are generated per REQ-014 and REQ-015.
REQ-026 When CLKGEN_TICK_EN is undefined, fastTick and slowTick are tied to constant 0 with no tick flops, and the ports remain present.

Verification
REQ-027 Defaults, rst high for 3 edges, then rst=0, en=1 -> clkFast=1 after edge 1 and toggles every edge; clkSlow=1 after edge 4, 0 after edge 8, period 8.
REQ-028 FAST_DIV=4, SLOW_DIV=12, en=1 for 48 edges -> clkFast 12 full periods, clkSlow 4 full periods; each clkSlow toggle coincides with a clkFast toggle.
REQ-029 Defaults, en dropped for 5 edges at edge 6 -> outputs and ticks frozen for those 5 edges; clkSlow next falls at edge 13 instead of 8.
REQ-030 Defaults, rst pulsed for 1 edge at edge 6 -> all outputs 0 on the next edge; clkSlow rises 4 edges after release.
REQ-031 CLKGEN_TICK_EN defined, defaults -> fastTick high in every cycle where clkFast rose (every 2 cycles); slowTick high once per 8 cycles, aligned with clkSlow rising.
REQ-032 CLKGEN_TICK_EN undefined -> fastTick and slowTick read 0 for 100 cycles, and clkFast/clkSlow are identical to REQ-027.

Source files
------------

// File: rtl/clock_generator_module.sv
`default_nettype none
// ============================================================================
// Module      : clock_generator_module
// Description : Derives two registered 50%-duty divided clocks (clkFast and
//               clkSlow) from a single system clock, with a shared count
//               enable and optional one-cycle strobes that mark each rising
//               transition of the divided clocks.
//               Optional feature macro: CLKGEN_TICK_EN
//                 defined   -> fastTick / slowTick strobes are generated
//                 undefined -> fastTick / slowTick are tied to 0 (no flops)
// Revision    : 1.0 - initial release
// ============================================================================
module clock_generator_module #(
    parameter int FAST_DIV = 2,
    parameter int SLOW_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic clkSlow,
    output logic clkFast,
    output logic slowTick,
    output logic fastTick
);

    // Half-period lengths in clk cycles; each counter runs 0..HALF-1.
    localparam int c_FAST_HALF = FAST_DIV / 2;
    localparam int c_SLOW_HALF = SLOW_DIV / 2;

    // A half period of one cycle still needs a 1-bit counter.
    localparam int c_FAST_W = (c_FAST_HALF > 1) ? $clog2(c_FAST_HALF) : 1;
    localparam int c_SLOW_W = (c_SLOW_HALF > 1) ? $clog2(c_SLOW_HALF) : 1;

    localparam logic [c_FAST_W-1:0] c_FAST_LAST = c_FAST_W'(c_FAST_HALF - 1);
    localparam logic [c_SLOW_W-1:0] c_SLOW_LAST = c_SLOW_W'(c_SLOW_HALF - 1);
    localparam logic [c_FAST_W-1:0] c_FAST_ONE  = c_FAST_W'(1);
    localparam logic [c_SLOW_W-1:0] c_SLOW_ONE  = c_SLOW_W'(1);

    // Reject illegal divider settings while elaborating.
    generate
        if ((FAST_DIV < 2) || ((FAST_DIV % 2) != 0)) begin : g_badFastDiv
            $error("clock_generator_module: FAST_DIV must be even and >= 2");
        end
        if ((SLOW_DIV < 2) || ((SLOW_DIV % 2) != 0)) begin : g_badSlowDiv
            $error("clock_generator_module: SLOW_DIV must be even and >= 2");
        end
        if ((FAST_DIV >= 2) && ((SLOW_DIV % FAST_DIV) != 0)) begin : g_badRatio
            $error("clock_generator_module: SLOW_DIV must be a multiple of FAST_DIV");
        end
    endgenerate

    logic [c_FAST_W-1:0] r_fCnt;
    logic [c_SLOW_W-1:0] r_sCnt;
    logic                r_clkFast;
    logic                r_clkSlow;
    logic                w_fWrap;
    logic                w_sWrap;

    // Terminal-count detection; a wrap only happens on an enabled edge.
    assign w_fWrap = en && (r_fCnt == c_FAST_LAST);
    assign w_sWrap = en && (r_sCnt == c_SLOW_LAST);

    // Fast divider: count half period, toggle clkFast and wrap to 0 at the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fCnt    <= '0;
            r_clkFast <= 1'b0;
        end else if (w_fWrap) begin
            r_fCnt    <= '0;
            r_clkFast <= ~r_clkFast;
        end else if (en) begin
            r_fCnt    <= r_fCnt + c_FAST_ONE;
        end
    end

    // Slow divider: same rule as the fast one; its wraps line up with fast
    // wraps because both start together and SLOW_DIV is a multiple of FAST_DIV.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sCnt    <= '0;
            r_clkSlow <= 1'b0;
        end else if (w_sWrap) begin
            r_sCnt    <= '0;
            r_clkSlow <= ~r_clkSlow;
        end else if (en) begin
            r_sCnt    <= r_sCnt + c_SLOW_ONE;
        end
    end

    assign clkFast = r_clkFast;
    assign clkSlow = r_clkSlow;

`ifdef CLKGEN_TICK_EN
    logic r_fastTick;
    logic r_slowTick;

    // Strobe is set on the same edge that drives a divided clock 0->1, so it
    // reads high in exactly the first cycle the clock reads high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fastTick <= 1'b0;
            r_slowTick <= 1'b0;
        end else begin
            r_fastTick <= w_fWrap && !r_clkFast;
            r_slowTick <= w_sWrap && !r_clkSlow;
        end
    end

    assign fastTick = r_fastTick;
    assign slowTick = r_slowTick;
`else
    assign fastTick = 1'b0;
    assign slowTick = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_generator_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_generator_module
// Description : Self-checking bench for clock_generator_module. Instance A
//               uses default dividers (2/8), instance B uses 4/12. Expected
//               values are pushed to a queue as each step is driven and
//               popped/compared after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_generator_module;

    localparam int c_A_FH = 1;   // FAST_DIV/2 for instance A
    localparam int c_A_SH = 4;   // SLOW_DIV/2 for instance A
    localparam int c_B_FH = 2;   // FAST_DIV/2 for instance B
    localparam int c_B_SH = 6;   // SLOW_DIV/2 for instance B

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic aSlow, aFast, aSTick, aFTick;
    logic bSlow, bFast, bSTick, bFTick;

    clock_generator_module #(.FAST_DIV(2), .SLOW_DIV(8)) dutA (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clkSlow  (aSlow),
        .clkFast  (aFast),
        .slowTick (aSTick),
        .fastTick (aFTick)
    );

    clock_generator_module #(.FAST_DIV(4), .SLOW_DIV(12)) dutB (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clkSlow  (bSlow),
        .clkFast  (bFast),
        .slowTick (bSTick),
        .fastTick (bFTick)
    );

    always #5 clk = ~clk;

    // {inputs, expected outputs of instance A}; rose flags become tick
    // expectations only when the tick feature is compiled in.
    typedef struct {
        logic r;
        logic e;
        logic fast;
        logic slow;
        logic fRose;
        logic sRose;
    } vec_t;

    typedef struct {
        logic aFast, aSlow, aFt, aSt;
        logic bFast, bSlow, bFt, bSt;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    int   stepNo   = 0;
    int   nA       = 0;   // enabled edges since reset, instance A
    int   nB       = 0;   // enabled edges since reset, instance B

    function automatic logic tickExp(input logic rose);
`ifdef CLKGEN_TICK_EN
        return rose;
`else
        return 1'b0 & rose;
`endif
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL step %0d %s: got %b expected %b", stepNo, name, act, exp);
        end
    endtask

    // Drive one edge. Instance A expectations come from the caller (table
    // or model); instance B always from the enabled-edge model.
    task automatic step(input logic r, input logic e, input logic useTab,
                        input logic tFast, input logic tSlow,
                        input logic tFr, input logic tSr);
        exp_t x;
        logic roseA, roseB;
        rst = r;
        en  = e;
        if (r) begin
            nA = 0;
            nB = 0;
        end else if (e) begin
            nA++;
            nB++;
        end
        roseA = !r && e && ((nA % (2 * c_A_FH)) == c_A_FH);
        x.aFast = useTab ? tFast : logic'((nA / c_A_FH) % 2);
        x.aSlow = useTab ? tSlow : logic'((nA / c_A_SH) % 2);
        x.aFt   = tickExp(useTab ? tFr : roseA);
        x.aSt   = tickExp(useTab ? tSr :
                          (!r && e && ((nA % (2 * c_A_SH)) == c_A_SH)));
        roseB   = !r && e && ((nB % (2 * c_B_FH)) == c_B_FH);
        x.bFast = logic'((nB / c_B_FH) % 2);
        x.bSlow = logic'((nB / c_B_SH) % 2);
        x.bFt   = tickExp(roseB);
        x.bSt   = tickExp(!r && e && ((nB % (2 * c_B_SH)) == c_B_SH));
        expQ.push_back(x);
        @(posedge clk);
        #1;
        stepNo++;
        x = expQ.pop_front();
        chk("A.clkFast",  aFast,  x.aFast);
        chk("A.clkSlow",  aSlow,  x.aSlow);
        chk("A.fastTick", aFTick, x.aFt);
        chk("A.slowTick", aSTick, x.aSt);
        chk("B.clkFast",  bFast,  x.bFast);
        chk("B.clkSlow",  bSlow,  x.bSlow);
        chk("B.fastTick", bFTick, x.bFt);
        chk("B.slowTick", bSTick, x.bSt);
    endtask

    vec_t tab[$];

    task automatic addV(input logic r, input logic e, input logic f,
                        input logic s, input logic fr, input logic sr);
        vec_t v;
        v.r = r; v.e = e; v.fast = f; v.slow = s; v.fRose = fr; v.sRose = sr;
        tab.push_back(v);
    endtask

    initial begin
        int bFastRises;
        int bSlowRises;
        int badAlign;
        logic pF, pS;

        // Reset for 3 edges, then free-running: fast every edge, slow at 4/8.
        repeat (3) addV(1, 0, 0, 0, 0, 0);
        addV(0, 1, 1, 0, 1, 0);
        addV(0, 1, 0, 0, 0, 0);
        addV(0, 1, 1, 0, 1, 0);
        addV(0, 1, 0, 1, 0, 1);
        addV(0, 1, 1, 1, 1, 0);
        addV(0, 1, 0, 1, 0, 0);
        addV(0, 1, 1, 1, 1, 0);
        addV(0, 1, 0, 0, 0, 0);
        addV(0, 1, 1, 0, 1, 0);
        addV(0, 1, 0, 0, 0, 0);
        // en low for 5 edges starting at edge 6: clkSlow falls at 13.
        addV(1, 0, 0, 0, 0, 0);
        addV(0, 1, 1, 0, 1, 0);
        addV(0, 1, 0, 0, 0, 0);
        addV(0, 1, 1, 0, 1, 0);
        addV(0, 1, 0, 1, 0, 1);
        addV(0, 1, 1, 1, 1, 0);
        repeat (5) addV(0, 0, 1, 1, 0, 0);
        addV(0, 1, 0, 1, 0, 0);
        addV(0, 1, 1, 1, 1, 0);
        addV(0, 1, 0, 0, 0, 0);
        addV(0, 1, 1, 0, 1, 0);
        // Reset pulse at edge 6 (with en high): clears, slow rises 4 later.
        addV(1, 0, 0, 0, 0, 0);
        addV(0, 1, 1, 0, 1, 0);
        addV(0, 1, 0, 0, 0, 0);
        addV(0, 1, 1, 0, 1, 0);
        addV(0, 1, 0, 1, 0, 1);
        addV(0, 1, 1, 1, 1, 0);
        addV(1, 1, 0, 0, 0, 0);
        addV(0, 1, 1, 0, 1, 0);
        addV(0, 1, 0, 0, 0, 0);
        addV(0, 1, 1, 0, 1, 0);
        addV(0, 1, 0, 1, 0, 1);

        for (int i = 0; i < tab.size(); i++)
            step(tab[i].r, tab[i].e, 1'b1, tab[i].fast, tab[i].slow,
                 tab[i].fRose, tab[i].sRose);

        // Instance B over 48 enabled edges: 12 fast and 4 slow periods, and
        // every slow toggle lands on a fast toggle.
        step(1, 0, 0, 0, 0, 0, 0);
        bFastRises = 0;
        bSlowRises = 0;
        badAlign   = 0;
        pF = bFast;
        pS = bSlow;
        for (int i = 0; i < 48; i++) begin
            step(0, 1, 0, 0, 0, 0, 0);
            if (!pF && bFast) bFastRises++;
            if (!pS && bSlow) bSlowRises++;
            if ((pS != bSlow) && (pF == bFast)) badAlign++;
            pF = bFast;
            pS = bSlow;
        end
        checks++;
        if (bFastRises != 12) begin
            failures++;
            $display("FAIL B.fastPeriods: got %0d expected 12", bFastRises);
        end
        checks++;
        if (bSlowRises != 4) begin
            failures++;
            $display("FAIL B.slowPeriods: got %0d expected 4", bSlowRises);
        end
        checks++;
        if (badAlign != 0) begin
            failures++;
            $display("FAIL B.slowAlign: got %0d misaligned toggles expected 0", badAlign);
        end

        // Randomised en gaps and occasional resets against the model.
        for (int i = 0; i < 300; i++) begin
            logic r, e;
            r = ($urandom_range(0, 39) == 0);
            e = ($urandom_range(0, 3) != 0);
            step(r, e, 0, 0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against any stall of the stimulus process.
    initial begin
        #200000;
        $display("FAIL timeout: stimulus did not complete");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
